// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//
// Resolves conditional branches, JAL and JALR in EX and computes the redirect
// target. Also holds a direct-mapped BTB with a 2-bit saturating counter per
// entry so that IF can predict taken branches and their targets.
//
// Ports:
//   clk_i              clock, all state changes on the rising edge
//   reset_i            synchronous, active-high reset
//   if_pc_i            fetch PC to look up
//   if_pred_taken_o    prediction for if_pc_i
//   if_pred_target_o   predicted target, 0 when not predicted taken
//   ex_valid_i         EX holds a live instruction
//   ex_pc_i            PC of the EX instruction
//   ex_imm_i           immediate
//   ex_alu_result_i    bit 0 = compare outcome; full word = JALR offset sum
//   ex_branch_i        instruction is a branch or jump
//   ex_jalr_i          instruction is JALR
//   ex_pred_taken_i    prediction carried with the instruction
//   ex_pred_target_i   predicted target carried with the instruction
//   ex_pc_four_o       ex_pc + 4
//   ex_pc_imm_o        ex_pc + ex_imm
//   ex_mispredict_o    redirect and flush required this cycle
//   ex_redirect_pc_o   correct next PC, valid with ex_mispredict_o
//   stat_branches_o    resolved branches since reset (saturating)
//   stat_mispredicts_o mispredictions since reset (saturating)
module branch_predict_unit #(
    parameter int unsigned PC_W    = 9,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [PC_W-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    output logic [31:0]      if_pred_target_o,
    input  logic             ex_valid_i,
    input  logic [PC_W-1:0]  ex_pc_i,
    input  logic [31:0]      ex_imm_i,
    input  logic [31:0]      ex_alu_result_i,
    input  logic             ex_branch_i,
    input  logic             ex_jalr_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_target_i,
    output logic [31:0]      ex_pc_four_o,
    output logic [31:0]      ex_pc_imm_o,
    output logic             ex_mispredict_o,
    output logic [31:0]      ex_redirect_pc_o,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispredicts_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    // BTB storage
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [1:0]       cnt_d    [ENTRIES];

    logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

    // Lookup
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx           = if_pc_i[IDX_W+1:2];
    assign if_tag           = if_pc_i[PC_W-1:IDX_W+2];
    assign if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken_o  = if_hit && cnt_q[if_idx][1];
    assign if_pred_target_o = if_pred_taken_o ? target_q[if_idx] : 32'd0;

    // Instruction-aligned low bits never address the BTB
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^if_pc_i[1:0];

    // Resolution
    logic [31:0]      ex_pc32;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             ex_update;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    assign ex_pc32      = 32'(ex_pc_i);
    assign ex_pc_four_o = ex_pc32 + 32'd4;
    assign ex_pc_imm_o  = ex_pc32 + ex_imm_i;
    assign res_taken    = ex_alu_result_i[0] | ex_jalr_i;
    assign res_target   = ex_jalr_i ? (ex_pc32 + ex_alu_result_i) : ex_pc_imm_o;
    assign ex_update    = ex_valid_i & ex_branch_i;
    assign ex_idx       = ex_pc_i[IDX_W+1:2];
    assign ex_tag       = ex_pc_i[PC_W-1:IDX_W+2];
    assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        ex_mispredict_o  = 1'b0;
        ex_redirect_pc_o = 32'd0;
        if (ex_update) begin
            ex_mispredict_o  = (res_taken != ex_pred_taken_i) ||
                               (res_taken && (res_target != ex_pred_target_i));
            ex_redirect_pc_o = res_taken ? res_target : ex_pc_four_o;
        end
    end

    // BTB and statistics next state
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        cnt_d              = cnt_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;

        if (ex_update) begin
            if (ex_hit) begin
                if (res_taken) begin
                    target_d[ex_idx] = res_target;
                    if (cnt_q[ex_idx] != 2'b11) begin
                        cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
                    end
                end else if (cnt_q[ex_idx] != 2'b00) begin
                    cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
                end
            end else begin
                // Allocate, replacing whatever was there
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = res_target;
                cnt_d[ex_idx]    = res_taken ? 2'b10 : 2'b01;
            end

            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + CNT_W'(1);
            end
            if (ex_mispredict_o && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_d = stat_mispredicts_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q            <= '{default: 1'b0};
            tag_q              <= '{default: '0};
            target_q           <= '{default: 32'd0};
            cnt_q              <= '{default: 2'b01};
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            cnt_q              <= cnt_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches_o    = stat_branches_q;
    assign stat_mispredicts_o = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: the stimulus process queues the
// expected value of each output it cares about; a monitor on the falling edge
// pops and compares.
module tb_branch_predict_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [8:0]  if_pc_i;
    logic        if_pred_taken_o;
    logic [31:0] if_pred_target_o;
    logic        ex_valid_i;
    logic [8:0]  ex_pc_i;
    logic [31:0] ex_imm_i;
    logic [31:0] ex_alu_result_i;
    logic        ex_branch_i;
    logic        ex_jalr_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic [31:0] ex_pc_four_o;
    logic [31:0] ex_pc_imm_o;
    logic        ex_mispredict_o;
    logic [31:0] ex_redirect_pc_o;
    logic [15:0] stat_branches_o;
    logic [15:0] stat_mispredicts_o;

    branch_predict_unit #(
        .PC_W   (9),
        .ENTRIES(16),
        .CNT_W  (16)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .if_pc_i           (if_pc_i),
        .if_pred_taken_o   (if_pred_taken_o),
        .if_pred_target_o  (if_pred_target_o),
        .ex_valid_i        (ex_valid_i),
        .ex_pc_i           (ex_pc_i),
        .ex_imm_i          (ex_imm_i),
        .ex_alu_result_i   (ex_alu_result_i),
        .ex_branch_i       (ex_branch_i),
        .ex_jalr_i         (ex_jalr_i),
        .ex_pred_taken_i   (ex_pred_taken_i),
        .ex_pred_target_i  (ex_pred_target_i),
        .ex_pc_four_o      (ex_pc_four_o),
        .ex_pc_imm_o       (ex_pc_imm_o),
        .ex_mispredict_o   (ex_mispredict_o),
        .ex_redirect_pc_o  (ex_redirect_pc_o),
        .stat_branches_o   (stat_branches_o),
        .stat_mispredicts_o(stat_mispredicts_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {SelTk, SelTgt, SelMp, SelRd, SelBr, SelMs, SelP4, SelPi} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function logic [31:0] pick(sel_e s);
        case (s)
            SelTk:   pick = 32'(if_pred_taken_o);
            SelTgt:  pick = if_pred_target_o;
            SelMp:   pick = 32'(ex_mispredict_o);
            SelRd:   pick = ex_redirect_pc_o;
            SelBr:   pick = 32'(stat_branches_o);
            SelMs:   pick = 32'(stat_mispredicts_o);
            SelP4:   pick = ex_pc_four_o;
            default: pick = ex_pc_imm_o;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every queued expectation for
    // this cycle is due at the falling edge.
    always @(negedge clk_i) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb_q.pop_front();
            act = pick(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input sel_e sel, input logic [31:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid_i       = 1'b0;
        ex_pc_i          = '0;
        ex_imm_i         = '0;
        ex_alu_result_i  = '0;
        ex_branch_i      = 1'b0;
        ex_jalr_i        = 1'b0;
        ex_pred_taken_i  = 1'b0;
        ex_pred_target_i = '0;
    endtask

    task automatic ex_drv(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic br, input logic jalr,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid_i       = v;
        ex_pc_i          = pc;
        ex_imm_i         = imm;
        ex_alu_result_i  = alu;
        ex_branch_i      = br;
        ex_jalr_i        = jalr;
        ex_pred_taken_i  = ptk;
        ex_pred_target_i = ptgt;
    endtask

    task automatic exp_pred(input logic tk, input logic [31:0] tgt, input string name);
        expect_v(SelTk, 32'(tk), {name, "_taken"});
        expect_v(SelTgt, tgt, {name, "_target"});
    endtask

    task automatic exp_res(input logic mp, input logic [31:0] rd, input string name);
        expect_v(SelMp, 32'(mp), {name, "_mispredict"});
        expect_v(SelRd, rd, {name, "_redirect"});
    endtask

    task automatic exp_stats(input int br, input int ms, input string name);
        expect_v(SelBr, 32'(br), {name, "_branches"});
        expect_v(SelMs, 32'(ms), {name, "_mispredicts"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        if_pc_i = 9'h010;
        ex_idle();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Reset state, cold lookup
        exp_pred(1'b0, 32'h0, "cold");
        exp_stats(0, 0, "reset");
        exp_res(1'b0, 32'h0, "idle");

        // Cold miss, taken, predicted not taken; lookup same cycle sees old state
        next_cycle();
        ex_drv(1, 9'h010, 32'h20, 32'h1, 1, 0, 0, 32'h0);
        exp_res(1'b1, 32'h030, "cold_br");
        expect_v(SelP4, 32'h014, "pc_four");
        expect_v(SelPi, 32'h030, "pc_imm");
        exp_pred(1'b0, 32'h0, "no_bypass");

        next_cycle();
        ex_idle();
        exp_pred(1'b1, 32'h030, "after_alloc");
        exp_stats(1, 1, "after_alloc");

        // Three correctly predicted taken updates: counter 10 -> 11 (saturates)
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ex_drv(1, 9'h010, 32'h20, 32'h1, 1, 0, 1, 32'h030);
            exp_res(1'b0, 32'h030, "sat_taken");
        end

        // Not taken: 11 -> 10, still predicted taken
        next_cycle();
        ex_drv(1, 9'h010, 32'h20, 32'h0, 1, 0, 1, 32'h030);
        exp_res(1'b1, 32'h014, "nt1");
        next_cycle();
        ex_idle();
        exp_pred(1'b1, 32'h030, "after_nt1");
        exp_stats(5, 2, "after_nt1");

        // Not taken again: 10 -> 01, no longer predicted
        next_cycle();
        ex_drv(1, 9'h010, 32'h20, 32'h0, 1, 0, 1, 32'h030);
        exp_res(1'b1, 32'h014, "nt2");

        // Lookup shows 01 -> not taken; same cycle retrain to 10
        next_cycle();
        ex_drv(1, 9'h010, 32'h20, 32'h1, 1, 0, 0, 32'h0);
        exp_pred(1'b0, 32'h0, "after_nt2");
        exp_res(1'b1, 32'h030, "retrain");

        // Aliasing: 0x050 shares index 4 with a different tag
        next_cycle();
        ex_idle();
        if_pc_i = 9'h050;
        exp_pred(1'b0, 32'h0, "alias_miss");
        exp_stats(7, 4, "before_alias");

        next_cycle();
        if_pc_i = 9'h010;
        ex_drv(1, 9'h050, 32'h40, 32'h1, 1, 0, 0, 32'h0);
        exp_pred(1'b1, 32'h030, "pre_evict");
        exp_res(1'b1, 32'h090, "alias_br");

        next_cycle();
        ex_idle();
        if_pc_i = 9'h050;
        exp_pred(1'b1, 32'h090, "alias_hit");

        next_cycle();
        if_pc_i = 9'h010;
        exp_pred(1'b0, 32'h0, "evicted");

        // JALR, wrong carried target then right one
        next_cycle();
        ex_drv(1, 9'h020, 32'h5, 32'h100, 1, 1, 1, 32'h0F0);
        exp_res(1'b1, 32'h120, "jalr_bad");

        next_cycle();
        if_pc_i = 9'h020;
        ex_drv(1, 9'h020, 32'h5, 32'h100, 1, 1, 1, 32'h120);
        exp_res(1'b0, 32'h120, "jalr_ok");
        exp_pred(1'b1, 32'h120, "jalr_pred");

        // Correctly predicted not-taken branch
        next_cycle();
        if_pc_i = 9'h040;
        ex_drv(1, 9'h040, 32'h10, 32'h0, 1, 0, 0, 32'h0);
        exp_res(1'b0, 32'h044, "nt_ok");

        // Squashed copy, squashed taken version, and a live non-branch
        next_cycle();
        ex_drv(0, 9'h040, 32'h10, 32'h0, 1, 0, 0, 32'h0);
        exp_res(1'b0, 32'h0, "squash");
        exp_stats(11, 6, "squash");
        next_cycle();
        ex_drv(0, 9'h040, 32'h10, 32'h1, 1, 0, 0, 32'h0);
        exp_res(1'b0, 32'h0, "squash_tk");
        next_cycle();
        ex_drv(1, 9'h040, 32'h10, 32'h1, 0, 0, 0, 32'h0);
        exp_res(1'b0, 32'h0, "non_branch");
        next_cycle();
        ex_idle();
        exp_pred(1'b0, 32'h0, "squash_nochange");
        exp_stats(11, 6, "squash_nochange");

        // Fill more entries
        next_cycle();
        ex_drv(1, 9'h004, 32'h8, 32'h1, 1, 0, 0, 32'h0);
        exp_res(1'b1, 32'h00C, "fill1");
        next_cycle();
        ex_drv(1, 9'h008, 32'h8, 32'h1, 1, 0, 0, 32'h0);
        next_cycle();
        ex_drv(1, 9'h00C, 32'h8, 32'h1, 1, 0, 0, 32'h0);
        next_cycle();
        ex_idle();
        if_pc_i = 9'h004;
        exp_pred(1'b1, 32'h00C, "filled");
        exp_stats(14, 9, "filled");

        // Reset with a concurrent update: update must be discarded
        next_cycle();
        reset_i = 1'b1;
        ex_drv(1, 9'h030, 32'h8, 32'h1, 1, 0, 0, 32'h0);
        next_cycle();
        reset_i = 1'b0;
        ex_idle();
        if_pc_i = 9'h004;
        exp_pred(1'b0, 32'h0, "rst_004");
        exp_stats(0, 0, "rst");
        next_cycle();
        if_pc_i = 9'h020;
        exp_pred(1'b0, 32'h0, "rst_020");
        next_cycle();
        if_pc_i = 9'h050;
        exp_pred(1'b0, 32'h0, "rst_050");
        next_cycle();
        if_pc_i = 9'h030;
        exp_pred(1'b0, 32'h0, "rst_030");

        next_cycle();
        next_cycle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
